// File: rtl/memory_board_ctrl.sv
// Game-state sequencer for the 4x4 memory-card board: cursor, face-up cards,
// matched pairs, move count and the select/compare/show-mismatch sequence.
module memory_board_ctrl #(
  parameter int SHOW_CYCLES = 50000000,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        new_game,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_sel,
  input  logic [47:0] layout,
  output logic [3:0]  cursor,
  output logic [15:0] face_up,
  output logic [15:0] matched,
  output logic [7:0]  moves,
  output logic        busy,
  output logic        game_done
);

  // state   | meaning
  // FIRST   | waiting for the first card of a pair
  // SECOND  | first card (idx_a) face-up, waiting for the second
  // COMPARE | one cycle: count the move, compare pair ids of idx_a/idx_b
  // SHOW    | mismatched pair stays revealed until the timer reaches zero
  // DONE    | every card matched; only new_game or reset leaves
  typedef enum logic [2:0] {S_FIRST, S_SECOND, S_COMPARE, S_SHOW, S_DONE} state_t;

  state_t             state, state_d;
  logic [3:0]         cursor_d, idx_a, idx_a_d, idx_b, idx_b_d;
  logic [15:0]        face_up_d, matched_d, pair_bits;
  logic [7:0]         moves_d;
  logic [CNT_W-1:0]   timer, timer_d;
  logic               busy_d, game_done_d, sel_ok;
  logic [2:0]         pair_id [16];

  always_comb begin
    for (int i = 0; i < 16; i++) pair_id[i] = layout[3*i +: 3];
  end

  assign sel_ok    = btn_sel && !face_up[cursor] && !matched[cursor];
  assign pair_bits = (16'b1 << idx_a) | (16'b1 << idx_b);

  always_comb begin
    state_d   = state;
    cursor_d  = cursor;
    face_up_d = face_up;
    matched_d = matched;
    moves_d   = moves;
    timer_d   = timer;
    idx_a_d   = idx_a;
    idx_b_d   = idx_b;
    if (new_game) begin
      state_d   = S_FIRST;
      cursor_d  = '0;
      face_up_d = '0;
      matched_d = '0;
      moves_d   = '0;
      timer_d   = '0;
      idx_a_d   = '0;
      idx_b_d   = '0;
    end else begin
      // Row moves step by 4 and wrap through the 4-bit index; column moves
      // touch only the low two bits so they wrap within the row.
      if (state != S_DONE) begin
        if (btn_up)         cursor_d = cursor - 4'd4;
        else if (btn_down)  cursor_d = cursor + 4'd4;
        else if (btn_left)  cursor_d = {cursor[3:2], cursor[1:0] - 2'd1};
        else if (btn_right) cursor_d = {cursor[3:2], cursor[1:0] + 2'd1};
      end
      case (state)
        S_FIRST: if (sel_ok) begin
          face_up_d[cursor] = 1'b1;
          idx_a_d           = cursor;
          state_d           = S_SECOND;
        end
        S_SECOND: if (sel_ok) begin
          face_up_d[cursor] = 1'b1;
          idx_b_d           = cursor;
          state_d           = S_COMPARE;
        end
        S_COMPARE: begin
          if (moves != 8'hFF) moves_d = moves + 8'd1;
          if (pair_id[idx_a] == pair_id[idx_b]) begin
            matched_d = matched | pair_bits;
            face_up_d = face_up & ~pair_bits;
            state_d   = (matched_d == 16'hFFFF) ? S_DONE : S_FIRST;
          end else begin
            timer_d = CNT_W'(SHOW_CYCLES - 1);
            state_d = S_SHOW;
          end
        end
        S_SHOW: begin
          if (timer == '0) begin
            face_up_d = face_up & ~pair_bits;
            state_d   = S_FIRST;
          end else begin
            timer_d = timer - 1'b1;
          end
        end
        default: ;
      endcase
    end
    busy_d      = (state_d == S_COMPARE) || (state_d == S_SHOW);
    game_done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_FIRST;
      cursor    <= '0;
      face_up   <= '0;
      matched   <= '0;
      moves     <= '0;
      timer     <= '0;
      idx_a     <= '0;
      idx_b     <= '0;
      busy      <= 1'b0;
      game_done <= 1'b0;
    end else begin
      state     <= state_d;
      cursor    <= cursor_d;
      face_up   <= face_up_d;
      matched   <= matched_d;
      moves     <= moves_d;
      timer     <= timer_d;
      idx_a     <= idx_a_d;
      idx_b     <= idx_b_d;
      busy      <= busy_d;
      game_done <= game_done_d;
    end
  end

endmodule

// File: tb/tb_memory_board_ctrl.sv
// Directed-vector bench for memory_board_ctrl with a short show time.
module tb_memory_board_ctrl;

  localparam logic [5:0] B_NEW   = 6'b100000;
  localparam logic [5:0] B_UP    = 6'b010000;
  localparam logic [5:0] B_DOWN  = 6'b001000;
  localparam logic [5:0] B_LEFT  = 6'b000100;
  localparam logic [5:0] B_RIGHT = 6'b000010;
  localparam logic [5:0] B_SEL   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        new_game = 1'b0;
  logic        btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_sel = 1'b0;
  logic [47:0] layout = '0;
  logic [3:0]  cursor;
  logic [15:0] face_up, matched;
  logic [7:0]  moves;
  logic        busy, game_done;

  int n_tests = 0;
  int n_fail  = 0;

  memory_board_ctrl #(.SHOW_CYCLES(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .new_game(new_game),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_sel(btn_sel), .layout(layout),
    .cursor(cursor), .face_up(face_up), .matched(matched),
    .moves(moves), .busy(busy), .game_done(game_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] c, input logic [15:0] fu,
                         input logic [15:0] m, input logic [7:0] mv, input logic b,
                         input logic d);
    chk({tag, ".cursor"}, 32'(cursor), 32'(c));
    chk({tag, ".face_up"}, 32'(face_up), 32'(fu));
    chk({tag, ".matched"}, 32'(matched), 32'(m));
    chk({tag, ".moves"}, 32'(moves), 32'(mv));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".game_done"}, 32'(game_done), 32'(d));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [5:0] b);
    {new_game, btn_up, btn_down, btn_left, btn_right, btn_sel} = b;
    tick();
    {new_game, btn_up, btn_down, btn_left, btn_right, btn_sel} = '0;
  endtask

  task automatic goto_pos(input logic [3:0] t);
    for (int i = 0; i < 4 && cursor[3:2] != t[3:2]; i++) press(B_DOWN);
    for (int i = 0; i < 4 && cursor[1:0] != t[1:0]; i++) press(B_RIGHT);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 4'd0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();

    // cursor movement and wrap
    repeat (3) press(B_RIGHT);
    chk("right3", 32'(cursor), 32'd3);
    press(B_DOWN);
    chk("down", 32'(cursor), 32'd7);
    press(B_UP);
    chk("up1", 32'(cursor), 32'd3);
    press(B_UP);
    chk("up_wrap", 32'(cursor), 32'd15);
    press(B_RIGHT);
    chk("right_wrap", 32'(cursor), 32'd12);
    press(B_NEW);
    chk("newgame_cursor", 32'(cursor), 32'd0);
    press(B_UP | B_RIGHT);
    chk("up_prio", 32'(cursor), 32'd12);
    press(B_NEW);

    // mismatch: pos0 id 1, pos2 id 2
    layout = '0;
    layout[2:0] = 3'd1;
    layout[8:6] = 3'd2;
    press(B_SEL);
    chk("mm_first", 32'(face_up), 32'h0001);
    press(B_RIGHT);
    press(B_RIGHT);
    press(B_SEL);
    chk_all("mm_compare", 4'd2, 16'h0005, 16'h0, 8'd0, 1'b1, 1'b0);
    press(B_RIGHT);
    chk_all("mm_show0", 4'd3, 16'h0005, 16'h0, 8'd1, 1'b1, 1'b0);
    for (int i = 1; i < 4; i++) begin
      press(B_SEL);
      chk($sformatf("mm_show%0d_fu", i), 32'(face_up), 32'h0005);
      chk($sformatf("mm_show%0d_busy", i), 32'(busy), 32'd1);
    end
    tick();
    chk_all("mm_hidden", 4'd3, 16'h0, 16'h0, 8'd1, 1'b0, 1'b0);
    press(B_SEL);
    chk("mm_first_again", 32'(face_up), 32'h0008);
    press(B_NEW);

    // match: pos0/pos1 id 5
    layout = '0;
    layout[2:0] = 3'd5;
    layout[5:3] = 3'd5;
    press(B_SEL);
    press(B_RIGHT);
    press(B_SEL);
    chk_all("m_compare", 4'd1, 16'h0003, 16'h0, 8'd0, 1'b1, 1'b0);
    tick();
    chk_all("m_matched", 4'd1, 16'h0, 16'h0003, 8'd1, 1'b0, 1'b0);

    // ignored selects
    press(B_SEL);
    chk_all("sel_matched", 4'd1, 16'h0, 16'h0003, 8'd1, 1'b0, 1'b0);
    press(B_RIGHT);
    press(B_SEL);
    chk("sel_a", 32'(face_up), 32'h0004);
    press(B_SEL);
    chk_all("resel_a", 4'd2, 16'h0004, 16'h0003, 8'd1, 1'b0, 1'b0);
    press(B_RIGHT | B_SEL);
    chk_all("move_sel_old", 4'd3, 16'h0004, 16'h0003, 8'd1, 1'b0, 1'b0);
    press(B_SEL);
    chk_all("sel_b", 4'd3, 16'h000C, 16'h0003, 8'd1, 1'b1, 1'b0);
    tick();
    chk_all("second_match", 4'd3, 16'h0, 16'h000F, 8'd2, 1'b0, 1'b0);
    press(B_NEW);

    // full solve: pair id = position / 2
    for (int i = 0; i < 16; i++) layout[3*i +: 3] = 3'(i / 2);
    for (int k = 0; k < 8; k++) begin
      goto_pos(4'(2 * k));
      press(B_SEL);
      press(B_RIGHT);
      press(B_SEL);
      tick();
      chk($sformatf("solve%0d_matched", k), 32'(matched), (32'd1 << (2 * k + 2)) - 32'd1);
      chk($sformatf("solve%0d_moves", k), 32'(moves), 32'(k + 1));
      chk($sformatf("solve%0d_done", k), 32'(game_done), 32'(k == 7));
    end
    press(B_UP | B_SEL);
    chk_all("done_ignore", 4'd15, 16'h0, 16'hFFFF, 8'd8, 1'b0, 1'b1);
    press(B_LEFT);
    chk("done_ignore_left", 32'(cursor), 32'd15);
    press(B_NEW | B_UP);
    chk_all("done_newgame", 4'd0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b0);

    // saturate moves with mismatches between pos0 (id 0) and pos1 (id 1)
    layout = '0;
    layout[5:3] = 3'd1;
    for (int i = 0; i < 256; i++) begin
      press(B_SEL);
      press(B_RIGHT);
      press(B_SEL);
      repeat (5) tick();
      press(B_LEFT);
      if (i == 254) chk("moves_255", 32'(moves), 32'd255);
    end
    chk_all("moves_sat", 4'd0, 16'h0, 16'h0, 8'd255, 1'b0, 1'b0);

    // async reset in the middle of SHOW
    press(B_SEL);
    press(B_RIGHT);
    press(B_SEL);
    tick();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_all("async_rst", 4'd0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) tick();
    chk_all("post_rst", 4'd0, 16'h0, 16'h0, 8'd0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
